dmem_responder: RTL and testbench

//   Data-memory responder for the MIPS core's load/store port. Accepts one request
//   at a time over a valid/ready handshake and inserts programmable wait states.

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory path.
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // A word access is legal only when the byte offset within the word is zero.
  function automatic logic addr_is_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data SRAM: synchronous write with per-byte strobe, async read.
// Contents are deliberately not reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Write the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states,
// valid/ready response out with misalignment / out-of-range error flag.
// Optional feature: define DMEM_BYTE_EN_EN to add the req_be byte-strobe port.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]        req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  if ((WAIT_CYCLES > 15) || (WAIT_CYCLES < 0)) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DATA_W != 32) begin : g_bad_data
    $error("dmem_responder: DATA_W must be 32");
  end

  dmem_state_t       state_r;
  logic [3:0]        cnt_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              lat_write_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [DATA_W-1:0] lat_wdata_r;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]        lat_be_r;
`endif

  logic              accept_s;
  logic              do_access_s;
  logic              acc_write_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic [3:0]        acc_be_s;
  logic              acc_err_s;
  logic              array_we_s;
  logic [31:0]       array_rdata_s;

  // Select the request being serviced: the live bus when it completes on the
  // accept edge (zero wait states), otherwise the latched copy; flag errors.
  always_comb begin
    accept_s    = req_valid && req_ready_r && (state_r == IDLE);
    do_access_s = 1'b0;
    if (state_r == WAIT) begin
      do_access_s = (cnt_r == 4'd1);
    end else if (WAIT_CYCLES == 0) begin
      do_access_s = accept_s;
    end else begin
      do_access_s = 1'b0;
    end
    if (state_r == IDLE) begin
      acc_write_s = req_write;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
`ifdef DMEM_BYTE_EN_EN
      acc_be_s    = req_be;
`else
      acc_be_s    = 4'hF;
`endif
    end else begin
      acc_write_s = lat_write_r;
      acc_addr_s  = lat_addr_r;
      acc_wdata_s = lat_wdata_r;
`ifdef DMEM_BYTE_EN_EN
      acc_be_s    = lat_be_r;
`else
      acc_be_s    = 4'hF;
`endif
    end
    acc_err_s  = !addr_is_aligned(acc_addr_s[1:0]) || (|acc_addr_s[ADDR_W-1:IDX_W+2]);
    array_we_s = do_access_s && acc_write_s && !acc_err_s && (|acc_be_s);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (array_we_s),
    .be   (acc_be_s),
    .idx  (acc_addr_s[IDX_W+1:2]),
    .wdata(acc_wdata_s),
    .rdata(array_rdata_s)
  );

  // Request/response FSM with wait-state counter and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      lat_write_r <= 1'b0;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
`ifdef DMEM_BYTE_EN_EN
      lat_be_r    <= 4'h0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            lat_write_r <= req_write;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
`ifdef DMEM_BYTE_EN_EN
            lat_be_r    <= req_be;
`endif
            cnt_r       <= 4'(WAIT_CYCLES);
            req_ready_r <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (do_access_s) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Capture response payload at the access edge; held stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else if (do_access_s) begin
      rsp_err_r   <= acc_err_s;
      rsp_rdata_r <= (acc_write_s || acc_err_s) ? '0 : array_rdata_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=256).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passed;
  int total;

  dmem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be   (req_be_v),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One request. lat counts clock edges from the edge that accepts the
  // request (inclusive) to the edge after which rsp_valid is seen high.
  // If rsp_ready is 1 the handshake edge is consumed before returning.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be_v  = be;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (rsp_valid === 1'b1) break;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be_v  = 4'hF;
    rsp_ready = 1'b1;

    // 1. Reset for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Store then load 0x10; latency 3 cycles each
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st10_lat",   32'(lat), 32'd3);
    check("st10_rdata", rd, 32'h0);
    check("st10_err",   {31'd0, er}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("ld10_lat",   32'(lat), 32'd3);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err",   {31'd0, er}, 32'd0);

    // 3. Misaligned load
    xact(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
    check("ld13_err",   {31'd0, er}, 32'd1);
    check("ld13_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("ld10b_rdata", rd, 32'hDEADBEEF);

    // 4. Out-of-range store must not alias onto word 0 or disturb 0x3FC
    xact(1'b1, 32'h0,   32'h11111111, 4'hF, rd, er, lat);
    xact(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    check("st3fc_err", {31'd0, er}, 32'd0);
    xact(1'b1, 32'h400, 32'h55AA55AA, 4'hF, rd, er, lat);
    check("st400_err",   {31'd0, er}, 32'd1);
    check("st400_rdata", rd, 32'h0);
    xact(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
    check("ld3fc_rdata", rd, 32'hCAFEF00D);
    check("ld3fc_err",   {31'd0, er}, 32'd0);
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    check("ld0_rdata", rd, 32'h11111111);

    // 5. Backpressure: response held 5 cycles, competing request ignored
    rsp_ready = 1'b0;
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("bp_rdata0", rd, 32'hDEADBEEF);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_ready", {31'd0, req_ready}, 32'd1);
    check("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("bp_no_store", rd, 32'hDEADBEEF);

    // 6. Reset mid-WAIT abandons a store
    xact(1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_wait_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("ld20_old", rd, 32'h0BADF00D);
    check("ld20_lat", 32'(lat), 32'd3);

`ifdef DMEM_BYTE_EN_EN
    // Byte strobes: partial merge, and an all-zero strobe is a legal no-op
    xact(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, er, lat);
    xact(1'b1, 32'h40, 32'hAABBCCDD, 4'b0011, rd, er, lat);
    check("be_st_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check("be_merge", rd, 32'hDEADCCDD);
    xact(1'b1, 32'h40, 32'h01020304, 4'h0, rd, er, lat);
    check("be0_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    check("be0_noop", rd, 32'hDEADCCDD);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
